// File: rtl/glitch_scheduler.sv
// Trigger-to-glitch pulse scheduler: after a trigger rise it waits DELAY cycles, then emits
// REPEAT pulses of WIDTH cycles separated by GAP cycles. Define GLITCH_TRIG_SYNC_EN for a 2-flop trigger synchronizer.
module glitch_scheduler #(
   parameter int DELAY_W  = 16,
   parameter int WIDTH_W  = 8,
   parameter int REPEAT_W = 8
) (
   input  logic        clk_in1,
   input  logic        rst_n,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   input  logic        arm,
   input  logic        abort,
   input  logic        trig_in,
   output logic        glitch_out,
   output logic        armed,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_PULSE,
      S_GAP
   } state_t;

   state_t              state_q;
   logic [DELAY_W-1:0]  delay_q;
   logic [WIDTH_W-1:0]  width_q;
   logic [WIDTH_W-1:0]  gap_q;
   logic [REPEAT_W-1:0] repeat_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [REPEAT_W-1:0] rep_q;
   logic                glitch_q;
   logic                armed_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic                trig_rise;
   logic                cfg_unused;

   logic [CNT_W-1:0]    delay_ld_d;
   logic [CNT_W-1:0]    width_ld_d;
   logic [CNT_W-1:0]    gap_ld_d;
   logic [REPEAT_W-1:0] rep_ld_d;

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   // Write data wider than the narrower registers is simply dropped.
   assign cfg_unused = ^cfg_wdata;

   assign delay_ld_d = CNT_W'(delay_q);
   assign width_ld_d = CNT_W'(width_q);
   assign gap_ld_d   = (gap_q == '0) ? CNT_W'(1) : CNT_W'(gap_q);
   assign rep_ld_d   = (repeat_q == '0) ? REPEAT_W'(1) : repeat_q;

`ifdef GLITCH_TRIG_SYNC_EN
   logic sync1_q, sync2_q, edge_q;

   always_ff @(posedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= trig_in;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   assign trig_rise = sync2_q & ~edge_q;
`else
   logic trig_q, edge_q;

   always_ff @(posedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
         trig_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         trig_q <= trig_in;
         edge_q <= trig_q;
      end
   end

   assign trig_rise = trig_q & ~edge_q;
`endif

   always_ff @(posedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         delay_q  <= '0;
         width_q  <= WIDTH_W'(1);
         gap_q    <= WIDTH_W'(1);
         repeat_q <= REPEAT_W'(1);
         cnt_q    <= '0;
         rep_q    <= '0;
         glitch_q <= 1'b0;
         armed_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (state_q != S_IDLE && abort) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rep_q    <= '0;
            glitch_q <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (cfg_we) begin
                     case (cfg_addr)
                        2'd0: delay_q  <= cfg_wdata[DELAY_W-1:0];
                        2'd1: width_q  <= cfg_wdata[WIDTH_W-1:0];
                        2'd2: gap_q    <= cfg_wdata[WIDTH_W-1:0];
                        2'd3: repeat_q <= cfg_wdata[REPEAT_W-1:0];
                     endcase
                  end
                  if (arm) begin
                     if (width_q == '0) begin
                        err_q <= 1'b1;
                     end else begin
                        state_q <= S_ARMED;
                        armed_q <= 1'b1;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               S_ARMED: begin
                  if (trig_rise) begin
                     rep_q   <= rep_ld_d;
                     armed_q <= 1'b0;
                     if (delay_q == '0) begin
                        state_q  <= S_PULSE;
                        cnt_q    <= width_ld_d;
                        glitch_q <= 1'b1;
                     end else begin
                        state_q <= S_DELAY;
                        cnt_q   <= delay_ld_d;
                     end
                  end
               end
               S_DELAY: begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_q  <= S_PULSE;
                     cnt_q    <= width_ld_d;
                     glitch_q <= 1'b1;
                  end else begin
                     cnt_q <= sat_dec(cnt_q);
                  end
               end
               S_PULSE: begin
                  if (cnt_q <= CNT_W'(1)) begin
                     glitch_q <= 1'b0;
                     // Last pulse of the burst ends the sequence; otherwise rest in GAP.
                     if (rep_q <= REPEAT_W'(1)) begin
                        state_q <= S_IDLE;
                        rep_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_GAP;
                        rep_q   <= rep_q - REPEAT_W'(1);
                        cnt_q   <= gap_ld_d;
                     end
                  end else begin
                     cnt_q <= sat_dec(cnt_q);
                  end
               end
               S_GAP: begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_q  <= S_PULSE;
                     cnt_q    <= width_ld_d;
                     glitch_q <= 1'b1;
                  end else begin
                     cnt_q <= sat_dec(cnt_q);
                  end
               end
               default: begin
                  state_q  <= S_IDLE;
                  glitch_q <= 1'b0;
                  armed_q  <= 1'b0;
                  busy_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign glitch_out = glitch_q;
   assign armed      = armed_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_glitch_scheduler.sv
// Directed bench for glitch_scheduler: timing of delay/pulse/gap/repeat, err, abort, async reset
// and ignored trigger/config cases, with expected edge patterns computed from the configuration.
module tb_glitch_scheduler;

   logic        clk_in1 = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        arm;
   logic        abort;
   logic        trig_in;
   logic        glitch_out;
   logic        armed;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

`ifdef GLITCH_TRIG_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   glitch_scheduler dut (
      .clk_in1   (clk_in1),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .arm       (arm),
      .abort     (abort),
      .trig_in   (trig_in),
      .glitch_out(glitch_out),
      .armed     (armed),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk_in1 = ~clk_in1;

   task automatic tick();
      @(posedge clk_in1);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // Raises trig_in; returns just after the first edge that samples it high (edge 0).
   task automatic trig_rise();
      trig_in = 1'b1;
      tick();
   endtask

   task automatic trig_low();
      trig_in = 1'b0;
      repeat (4) tick();
   endtask

   // Bit i of g/d holds glitch_out/done just after edge i.
   task automatic capture(input int n, output logic [63:0] g, output logic [63:0] d);
      g = '0;
      d = '0;
      for (int i = 1; i <= n; i++) begin
         tick();
         g[i] = glitch_out;
         d[i] = done;
      end
   endtask

   task automatic test_reset();
      total++; if (glitch_out !== 1'b0) begin bad++; $display("FAIL rst_glitch got=%b exp=0", glitch_out); end
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL rst_armed got=%b exp=0", armed); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
   endtask

   task automatic test_single();
      logic [63:0] g, d, eg, ed;
      cfg_write(2'd0, 16'd5);
      cfg_write(2'd1, 16'd3);
      cfg_write(2'd3, 16'd1);
      do_arm();
      total++; if (armed !== 1'b1) begin bad++; $display("FAIL single_armed got=%b exp=1", armed); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
      trig_rise();
      capture(20, g, d);
      eg = '0; ed = '0;
      for (int i = 0; i < 3; i++) eg[5 + LAT + i] = 1'b1;
      ed[5 + LAT + 3] = 1'b1;
      total++; if (g !== eg) begin bad++; $display("FAIL single_glitch got=%h exp=%h", g, eg); end
      total++; if (d !== ed) begin bad++; $display("FAIL single_done got=%h exp=%h", d, ed); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
      trig_low();
   endtask

   task automatic test_repeat();
      logic [63:0] g, d, eg, ed;
      cfg_write(2'd0, 16'd0);
      cfg_write(2'd1, 16'd2);
      cfg_write(2'd2, 16'd4);
      cfg_write(2'd3, 16'd3);
      do_arm();
      trig_rise();
      capture(30, g, d);
      eg = '0; ed = '0;
      for (int k = 0; k < 3; k++) begin
         eg[LAT + 6 * k]     = 1'b1;
         eg[LAT + 6 * k + 1] = 1'b1;
      end
      ed[LAT + 14] = 1'b1;
      total++; if (g !== eg) begin bad++; $display("FAIL repeat_glitch got=%h exp=%h", g, eg); end
      total++; if (d !== ed) begin bad++; $display("FAIL repeat_done got=%h exp=%h", d, ed); end
      trig_low();
   endtask

   task automatic test_width_zero();
      logic [63:0] g, d;
      cfg_write(2'd1, 16'd0);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL wz_err got=%b exp=1", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wz_busy got=%b exp=0", busy); end
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL wz_armed got=%b exp=0", armed); end
      total++; if (glitch_out !== 1'b0) begin bad++; $display("FAIL wz_glitch got=%b exp=0", glitch_out); end
      tick();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL wz_err_clear got=%b exp=0", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wz_busy2 got=%b exp=0", busy); end
      trig_rise();
      capture(10, g, d);
      total++; if (g !== 64'd0) begin bad++; $display("FAIL wz_no_glitch got=%h exp=0", g); end
      trig_low();
   endtask

   task automatic test_abort();
      logic [63:0] g, d;
      cfg_write(2'd0, 16'd0);
      cfg_write(2'd1, 16'd4);
      cfg_write(2'd2, 16'd2);
      cfg_write(2'd3, 16'd4);
      do_arm();
      trig_rise();
      repeat (LAT + 7) tick();
      total++; if (glitch_out !== 1'b1) begin bad++; $display("FAIL abort_pulse2 got=%b exp=1", glitch_out); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++; if (glitch_out !== 1'b0) begin bad++; $display("FAIL abort_glitch got=%b exp=0", glitch_out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL abort_armed got=%b exp=0", armed); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
      capture(30, g, d);
      total++; if (g !== 64'd0) begin bad++; $display("FAIL abort_after_glitch got=%h exp=0", g); end
      total++; if (d !== 64'd0) begin bad++; $display("FAIL abort_after_done got=%h exp=0", d); end
      trig_low();
      // Abort arriving in the same cycle the trigger rise is seen must win.
      do_arm();
      total++; if (armed !== 1'b1) begin bad++; $display("FAIL race_armed got=%b exp=1", armed); end
      trig_in = 1'b1;
      repeat (LAT) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL race_busy got=%b exp=0", busy); end
      capture(15, g, d);
      total++; if (g !== 64'd0) begin bad++; $display("FAIL race_glitch got=%h exp=0", g); end
      trig_low();
   endtask

   task automatic test_reset_mid();
      logic [63:0] g, d, eg, ed;
      cfg_write(2'd0, 16'd0);
      cfg_write(2'd1, 16'd10);
      cfg_write(2'd3, 16'd1);
      do_arm();
      trig_rise();
      repeat (LAT + 2) tick();
      total++; if (glitch_out !== 1'b1) begin bad++; $display("FAIL rmid_pulse got=%b exp=1", glitch_out); end
      #2;
      rst_n   = 1'b0;
      trig_in = 1'b0;
      #1;
      total++; if (glitch_out !== 1'b0) begin bad++; $display("FAIL rmid_async_glitch got=%b exp=0", glitch_out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      do_arm();
      trig_rise();
      capture(10, g, d);
      eg = '0; ed = '0;
      eg[LAT] = 1'b1;
      ed[LAT + 1] = 1'b1;
      total++; if (g !== eg) begin bad++; $display("FAIL rmid_dflt_glitch got=%h exp=%h", g, eg); end
      total++; if (d !== ed) begin bad++; $display("FAIL rmid_dflt_done got=%h exp=%h", d, ed); end
      trig_low();
      cfg_write(2'd3, 16'd2);
      do_arm();
      trig_rise();
      capture(10, g, d);
      eg = '0; ed = '0;
      eg[LAT] = 1'b1;
      eg[LAT + 2] = 1'b1;
      ed[LAT + 3] = 1'b1;
      total++; if (g !== eg) begin bad++; $display("FAIL rmid_gap_glitch got=%h exp=%h", g, eg); end
      total++; if (d !== ed) begin bad++; $display("FAIL rmid_gap_done got=%h exp=%h", d, ed); end
      trig_low();
   endtask

   task automatic test_held_trig();
      logic [63:0] g, d, eg, ed;
      cfg_write(2'd0, 16'd3);
      cfg_write(2'd1, 16'd1);
      cfg_write(2'd3, 16'd1);
      trig_in = 1'b1;
      repeat (4) tick();
      do_arm();
      total++; if (armed !== 1'b1) begin bad++; $display("FAIL held_armed got=%b exp=1", armed); end
      cfg_write(2'd0, 16'd9);
      capture(12, g, d);
      total++; if (g !== 64'd0) begin bad++; $display("FAIL held_no_glitch got=%h exp=0", g); end
      total++; if (armed !== 1'b1) begin bad++; $display("FAIL held_still_armed got=%b exp=1", armed); end
      trig_in = 1'b0;
      repeat (3) tick();
      trig_rise();
      capture(12, g, d);
      eg = '0; ed = '0;
      eg[3 + LAT] = 1'b1;
      ed[3 + LAT + 1] = 1'b1;
      total++; if (g !== eg) begin bad++; $display("FAIL held_delay_kept got=%h exp=%h", g, eg); end
      total++; if (d !== ed) begin bad++; $display("FAIL held_done got=%h exp=%h", d, ed); end
      trig_low();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = 2'd0;
      cfg_wdata = 16'd0;
      arm       = 1'b0;
      abort     = 1'b0;
      trig_in   = 1'b0;
      #12;
      rst_n = 1'b1;
      tick();
      test_reset();
      test_single();
      test_repeat();
      test_width_zero();
      test_abort();
      test_reset_mid();
      test_held_trig();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
